// File: rtl/rv32i_types.sv
// Shared machine-wide parameters and the common data bus result type used by
// the functional-unit result queues and the CDB arbiter.
package params;
    localparam int EBR_MASK_SIZE = 4;
    localparam int ROB_TAG_W     = 6;
endpackage

package rv32i_types;
    import params::*;

    typedef struct packed {
        logic                     valid;
        logic [EBR_MASK_SIZE-1:0] ebr_mask;
        logic [ROB_TAG_W-1:0]     tag;
        logic [31:0]              data;
    } cdb_t;
endpackage

// File: rtl/ebr_resolve.sv
// Applies one branch resolution broadcast to a single branch-dependency mask:
// clears the resolved branch bit and flags the owner as squashed on a mispredict.
module ebr_resolve
    import params::*;
(
    input  logic                     bra_done,
    input  logic                     bra_mispredict,
    input  logic [EBR_MASK_SIZE-1:0] bra_id,
    input  logic [EBR_MASK_SIZE-1:0] mask_i,
    output logic [EBR_MASK_SIZE-1:0] mask_o,
    output logic                     invalid_o
);
    logic hit;

    assign hit       = |(mask_i & bra_id);
    assign invalid_o = bra_done && bra_mispredict && hit;
    assign mask_o    = bra_done ? (mask_i & ~bra_id) : mask_i;
endmodule

// File: rtl/fu_cdb_fifo.sv
// Per-functional-unit result queue in front of the CDB arbiter. Entries stay
// branch-resolved while queued; squashed entries drain without being presented.
module fu_cdb_fifo
    import params::*;
    import rv32i_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fu_valid,
    input  cdb_t                     fu_wdata,
    output logic                     fu_ready,
    output logic                     out_valid,
    output cdb_t                     out_data,
    input  logic                     dequeue,
    input  logic                     bra_done,
    input  logic                     bra_mispredict,
    input  logic [EBR_MASK_SIZE-1:0] bra_id
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    cdb_t                     queue_q [DEPTH];
    cdb_t                     queue_d [DEPTH];
    logic [PTR_W-1:0]         head_q, head_d;
    logic [PTR_W-1:0]         tail_q, tail_d;
    logic [CNT_W-1:0]         count_q, count_d;

    logic [EBR_MASK_SIZE-1:0] ent_mask [DEPTH];
    logic                     ent_inv  [DEPTH];
    logic [EBR_MASK_SIZE-1:0] in_mask;
    logic                     in_inv;
    logic                     not_empty;
    logic                     write;
    logic                     pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent_res
        ebr_resolve u_res (
            .bra_done       (bra_done),
            .bra_mispredict (bra_mispredict),
            .bra_id         (bra_id),
            .mask_i         (queue_q[i].ebr_mask),
            .mask_o         (ent_mask[i]),
            .invalid_o      (ent_inv[i])
        );
    end

    ebr_resolve u_in_res (
        .bra_done       (bra_done),
        .bra_mispredict (bra_mispredict),
        .bra_id         (bra_id),
        .mask_i         (fu_wdata.ebr_mask),
        .mask_o         (in_mask),
        .invalid_o      (in_inv)
    );

    // Head is shown unresolved; the arbiter resolves same-cycle branches itself.
    assign not_empty = (count_q != '0);
    assign fu_ready  = (count_q != CNT_W'(DEPTH));
    assign out_data  = queue_q[head_q];
    assign out_valid = not_empty && queue_q[head_q].valid;
    assign write     = fu_valid && fu_ready && fu_wdata.valid && !in_inv;
    assign pop       = (dequeue && out_valid) || (not_empty && !queue_q[head_q].valid);

    always_comb begin
        head_d  = pop   ? next_ptr(head_q) : head_q;
        tail_d  = write ? next_ptr(tail_q) : tail_q;
        count_d = count_q;
        case ({write, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        for (int i = 0; i < DEPTH; i++) begin
            queue_d[i]          = queue_q[i];
            queue_d[i].ebr_mask = ent_mask[i];
            queue_d[i].valid    = queue_q[i].valid && !ent_inv[i];
            if (pop && (head_q == PTR_W'(i))) begin
                queue_d[i].valid = 1'b0;
            end
            // Write and pop never share a slot: that needs count 0 or count DEPTH.
            if (write && (tail_q == PTR_W'(i))) begin
                queue_d[i]          = fu_wdata;
                queue_d[i].ebr_mask = in_mask;
                queue_d[i].valid    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                queue_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                queue_q[i] <= queue_d[i];
            end
        end
    end
endmodule

// File: tb/tb_fu_cdb_fifo.sv
// Directed bench for fu_cdb_fifo: a DEPTH=4 instance for ordering, backpressure
// and branch resolution, and a DEPTH=3 instance for pointer wrap and reset.
module tb_fu_cdb_fifo;
    import params::*;
    import rv32i_types::*;

    logic clk;

    logic                     a_rst, a_fu_valid, a_fu_ready, a_out_valid, a_dequeue;
    logic                     a_bra_done, a_bra_mispredict;
    logic [EBR_MASK_SIZE-1:0] a_bra_id;
    cdb_t                     a_wdata, a_out_data;

    logic                     b_rst, b_fu_valid, b_fu_ready, b_out_valid, b_dequeue;
    logic                     b_bra_done, b_bra_mispredict;
    logic [EBR_MASK_SIZE-1:0] b_bra_id;
    cdb_t                     b_wdata, b_out_data;

    int n_checks = 0;
    int n_fail   = 0;

    fu_cdb_fifo #(.DEPTH(4)) dut_a (
        .clk            (clk),
        .rst            (a_rst),
        .fu_valid       (a_fu_valid),
        .fu_wdata       (a_wdata),
        .fu_ready       (a_fu_ready),
        .out_valid      (a_out_valid),
        .out_data       (a_out_data),
        .dequeue        (a_dequeue),
        .bra_done       (a_bra_done),
        .bra_mispredict (a_bra_mispredict),
        .bra_id         (a_bra_id)
    );

    fu_cdb_fifo #(.DEPTH(3)) dut_b (
        .clk            (clk),
        .rst            (b_rst),
        .fu_valid       (b_fu_valid),
        .fu_wdata       (b_wdata),
        .fu_ready       (b_fu_ready),
        .out_valid      (b_out_valid),
        .out_data       (b_out_data),
        .dequeue        (b_dequeue),
        .bra_done       (b_bra_done),
        .bra_mispredict (b_bra_mispredict),
        .bra_id         (b_bra_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic cdb_t mk(input logic v, input logic [3:0] m, input logic [5:0] t);
        cdb_t r;
        r.valid    = v;
        r.ebr_mask = m;
        r.tag      = t;
        r.data     = 32'hC0DE_0000 | {26'h0, t};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        a_rst = 1'b1; a_fu_valid = 1'b0; a_wdata = '0; a_dequeue = 1'b0;
        a_bra_done = 1'b0; a_bra_mispredict = 1'b0; a_bra_id = '0;
        b_rst = 1'b1; b_fu_valid = 1'b0; b_wdata = '0; b_dequeue = 1'b0;
        b_bra_done = 1'b0; b_bra_mispredict = 1'b0; b_bra_id = '0;
        tick();
        a_rst = 1'b0;
        b_rst = 1'b0;

        chk("a_rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("a_rst_out_data",  64'(a_out_data),  64'd0);
        chk("a_rst_fu_ready",  64'(a_fu_ready),  64'd1);

        // Fill and drain with dequeue tied high: each result visible one cycle after its write.
        a_dequeue = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            a_fu_valid = 1'b1;
            a_wdata    = mk(1'b1, 4'b0000, 6'(t));
            tick();
            chk("fill_out_valid", 64'(a_out_valid), 64'd1);
            chk("fill_out_data",  64'(a_out_data),  64'(mk(1'b1, 4'b0000, 6'(t))));
        end
        a_fu_valid = 1'b0;
        tick();
        chk("drain_empty_valid", 64'(a_out_valid), 64'd0);
        chk("drain_empty_ready", 64'(a_fu_ready),  64'd1);

        // Backpressure: five writes, only four stored.
        a_dequeue = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_fu_valid = 1'b1;
            a_wdata    = mk(1'b1, 4'b0000, 6'(11 + i));
            tick();
            chk("bp_fu_ready", 64'(a_fu_ready), (i < 3) ? 64'd1 : 64'd0);
        end
        chk("bp_head_tag", 64'(a_out_data.tag), 64'd11);
        a_dequeue = 1'b1;
        a_wdata   = mk(1'b1, 4'b0000, 6'd15);
        tick();
        chk("bp_pop_full_ready", 64'(a_fu_ready),     64'd1);
        chk("bp_pop_full_head",  64'(a_out_data.tag), 64'd12);
        a_fu_valid = 1'b0;
        tick();
        chk("bp_drain_13", 64'(a_out_data.tag), 64'd13);
        tick();
        chk("bp_drain_14", 64'(a_out_data.tag), 64'd14);
        tick();
        chk("bp_no_15", 64'(a_out_valid), 64'd0);

        // Mispredict squash of branch 0001.
        a_dequeue = 1'b0;
        a_fu_valid = 1'b1; a_wdata = mk(1'b1, 4'b0001, 6'd21); tick();
        a_wdata = mk(1'b1, 4'b0010, 6'd22); tick();
        a_wdata = mk(1'b1, 4'b0001, 6'd23); tick();
        chk("sq_pre_head", 64'(a_out_data.tag), 64'd21);
        a_fu_valid = 1'b0;
        a_bra_done = 1'b1; a_bra_mispredict = 1'b1; a_bra_id = 4'b0001;
        tick();
        a_bra_done = 1'b0; a_bra_mispredict = 1'b0; a_bra_id = '0;
        chk("sq_head_hidden", 64'(a_out_valid), 64'd0);
        tick();
        chk("sq_survivor_valid", 64'(a_out_valid), 64'd1);
        chk("sq_survivor_data",  64'(a_out_data),  64'(mk(1'b1, 4'b0010, 6'd22)));
        a_dequeue = 1'b1;
        tick();
        chk("sq_tail_hidden", 64'(a_out_valid), 64'd0);
        a_dequeue = 1'b0;
        tick();
        chk("sq_drained", 64'(a_out_valid), 64'd0);

        // Correct prediction of branch 0001: all survive, bit cleared.
        a_fu_valid = 1'b1; a_wdata = mk(1'b1, 4'b0001, 6'd31); tick();
        a_wdata = mk(1'b1, 4'b0010, 6'd32); tick();
        a_wdata = mk(1'b1, 4'b0001, 6'd33); tick();
        a_fu_valid = 1'b0;
        a_bra_done = 1'b1; a_bra_mispredict = 1'b0; a_bra_id = 4'b0001;
        tick();
        a_bra_done = 1'b0; a_bra_id = '0;
        chk("cp_e0", 64'(a_out_data), 64'(mk(1'b1, 4'b0000, 6'd31)));
        a_dequeue = 1'b1;
        tick();
        chk("cp_e1", 64'(a_out_data), 64'(mk(1'b1, 4'b0010, 6'd32)));
        tick();
        chk("cp_e2", 64'(a_out_data), 64'(mk(1'b1, 4'b0000, 6'd33)));
        tick();
        chk("cp_empty", 64'(a_out_valid), 64'd0);
        a_dequeue = 1'b0;

        // Incoming result squashed by a same-cycle mispredict is dropped.
        a_fu_valid = 1'b1; a_wdata = mk(1'b1, 4'b0100, 6'd41);
        a_bra_done = 1'b1; a_bra_mispredict = 1'b1; a_bra_id = 4'b0100;
        tick();
        chk("ws_not_written", 64'(a_out_valid), 64'd0);
        a_bra_done = 1'b0; a_bra_mispredict = 1'b0; a_bra_id = '0;
        a_wdata = mk(1'b1, 4'b0000, 6'd42);
        tick();
        chk("ws_next_head", 64'(a_out_data), 64'(mk(1'b1, 4'b0000, 6'd42)));
        // Incoming mask resolved on write during a correct prediction.
        a_wdata = mk(1'b1, 4'b0110, 6'd43);
        a_bra_done = 1'b1; a_bra_id = 4'b0010;
        tick();
        a_bra_done = 1'b0; a_bra_id = '0;
        a_fu_valid = 1'b0; a_dequeue = 1'b1;
        tick();
        chk("wr_resolved", 64'(a_out_data), 64'(mk(1'b1, 4'b0100, 6'd43)));
        tick();
        chk("wr_empty", 64'(a_out_valid), 64'd0);
        a_dequeue = 1'b0;

        // DEPTH=3: streaming write/pop so both pointers wrap twice.
        b_dequeue = 1'b1;
        for (int t = 51; t <= 57; t++) begin
            b_fu_valid = 1'b1;
            b_wdata    = mk(1'b1, 4'b0000, 6'(t));
            tick();
            chk("wrap_order", 64'(b_out_data), 64'(mk(1'b1, 4'b0000, 6'(t))));
        end
        b_dequeue = 1'b0;
        b_wdata = mk(1'b1, 4'b0000, 6'd58);
        tick();
        chk("wrap_hold_head",  64'(b_out_data.tag), 64'd57);
        chk("wrap_hold_ready", 64'(b_fu_ready),     64'd1);
        // Reset with two entries held, against a concurrent write, pop and resolution.
        b_rst = 1'b1; b_dequeue = 1'b1; b_wdata = mk(1'b1, 4'b0001, 6'd59);
        b_bra_done = 1'b1; b_bra_mispredict = 1'b1; b_bra_id = 4'b0001;
        tick();
        chk("b_rst_out_valid", 64'(b_out_valid), 64'd0);
        chk("b_rst_out_data",  64'(b_out_data),  64'd0);
        chk("b_rst_fu_ready",  64'(b_fu_ready),  64'd1);
        b_rst = 1'b0; b_fu_valid = 1'b0; b_dequeue = 1'b0;
        b_bra_done = 1'b0; b_bra_mispredict = 1'b0; b_bra_id = '0;
        tick();
        chk("b_post_rst_empty", 64'(b_out_valid), 64'd0);
        // DEPTH=3 full after three writes.
        for (int t = 61; t <= 63; t++) begin
            b_fu_valid = 1'b1;
            b_wdata    = mk(1'b1, 4'b0000, 6'(t));
            tick();
        end
        b_fu_valid = 1'b0;
        chk("b_full_ready", 64'(b_fu_ready),     64'd0);
        chk("b_full_head",  64'(b_out_data.tag), 64'd61);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
